// File: rtl/arm_sequencer_pkg.sv
// Shared definitions for the arm sequencer and the ALU datapath: state
// encoding, control opcode values and instruction field positions.
package arm_sequencer_pkg;

  // Sequencer states; the encoding itself is never visible outside the core.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC1 = 3'd2,
    ST_EXEC2 = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  // Instruction field positions. Bit 15 selects ALU (1) versus control (0).
  localparam int ARM_BIT = 15;
  localparam int OP_MSB  = 14;
  localparam int OP_LSB  = 12;

  // Control opcodes carried in the op field when the ALU bit is clear.
  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_JZ   = 3'b010;
  localparam logic [2:0] OP_HALT = 3'b011;

  // Extract the op field from an instruction word.
  function automatic logic [2:0] getOp(input logic [15:0] instWord);
    return instWord[OP_MSB:OP_LSB];
  endfunction

  // True when the instruction is executed by the ALU.
  function automatic logic isAluOp(input logic [15:0] instWord);
    return instWord[ARM_BIT];
  endfunction

endpackage

// File: rtl/arm_next_pc.sv
// Combinational next-PC selection. Given the decoded instruction fields, the
// current PC and the zero flag, it picks the PC for the following fetch and
// flags HALT so the sequencer can park.
module arm_next_pc
  import arm_sequencer_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            i_aluOp,
  input  logic [2:0]      i_op,
  input  logic [PC_W-1:0] i_target,
  input  logic [PC_W-1:0] i_pc,
  input  logic            i_zflag,
  output logic [PC_W-1:0] o_nextPc,
  output logic            o_isHalt
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  logic [PC_W-1:0] w_pcInc;

  // Sequential successor; wraps naturally at the top of the address space.
  assign w_pcInc = i_pc + PC_ONE;

  // Choose the next PC: ALU ops and unknown control ops fall through to pc+1.
  always_comb begin
    o_nextPc = w_pcInc;
    o_isHalt = 1'b0;
    if (!i_aluOp) begin
      case (i_op)
        OP_JMP:  o_nextPc = i_target;
        OP_JZ:   o_nextPc = i_zflag ? i_target : w_pcInc;
        OP_HALT: begin
          o_nextPc = i_pc;
          o_isHalt = 1'b1;
        end
        default: o_nextPc = w_pcInc;
      endcase
    end
  end

endmodule

// File: rtl/arm_sequencer.sv
// Instruction sequencer for the 16-bit Harvard core. Fetches a word from
// program memory, presents it to the ALU for one exec1 cycle, captures the
// zero flag from ALU results, then resolves control flow in EXEC2.
module arm_sequencer
  import arm_sequencer_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_rdata,
  input  logic            imem_valid,
  input  logic [15:0]     alu_result,
  output logic [15:0]     inst,
  output logic            exec1,
  output logic [PC_W-1:0] pc,
  output logic            zflag,
  output logic            halted
);

  state_t          r_state;
  state_t          w_nextState;
  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_inst;
  logic            r_zflag;
  logic [PC_W-1:0] w_nextPc;
  logic            w_isHalt;

  arm_next_pc #(
    .PC_W(PC_W)
  ) u_nextPc (
    .i_aluOp  (isAluOp(r_inst)),
    .i_op     (getOp(r_inst)),
    .i_target (r_inst[PC_W-1:0]),
    .i_pc     (r_pc),
    .i_zflag  (r_zflag),
    .o_nextPc (w_nextPc),
    .o_isHalt (w_isHalt)
  );

  // State register; reset returns to IDLE from anywhere, abandoning a fetch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; run only matters in IDLE and HALT is left only by reset.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:  if (run) w_nextState = ST_FETCH;
      ST_FETCH: if (imem_valid) w_nextState = ST_EXEC1;
      ST_EXEC1: w_nextState = ST_EXEC2;
      ST_EXEC2: w_nextState = w_isHalt ? ST_HALT : ST_FETCH;
      ST_HALT:  w_nextState = ST_HALT;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  // Moore outputs decoded purely from the current state.
  always_comb begin
    imem_req = 1'b0;
    exec1    = 1'b0;
    halted   = 1'b0;
    case (r_state)
      ST_FETCH: imem_req = 1'b1;
      ST_EXEC1: exec1    = 1'b1;
      ST_HALT:  halted   = 1'b1;
      default: begin
        imem_req = 1'b0;
        exec1    = 1'b0;
        halted   = 1'b0;
      end
    endcase
  end

  // Datapath: capture the fetched word, latch the zero flag, advance the PC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_inst  <= 16'h0000;
      r_zflag <= 1'b0;
    end else begin
      if (r_state == ST_FETCH && imem_valid) begin
        r_inst <= imem_rdata;
      end
      if (r_state == ST_EXEC1 && isAluOp(r_inst)) begin
        r_zflag <= (alu_result == 16'h0000);
      end
      if (r_state == ST_EXEC2) begin
        r_pc <= w_nextPc;
      end
    end
  end

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign inst      = r_inst;
  assign zflag     = r_zflag;

endmodule

// File: tb/tb_arm_sequencer.sv
// Testbench for arm_sequencer. An instruction-level model of the core
// (program counter and zero flag updated per instruction) predicts the
// architectural result of every instruction fed through a randomised-latency
// memory responder.
module tb_arm_sequencer;

  localparam int PC_W = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            run;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_rdata;
  logic            imem_valid;
  logic [15:0]     alu_result;
  logic [15:0]     inst;
  logic            exec1;
  logic [PC_W-1:0] pc;
  logic            zflag;
  logic            halted;

  int nChecks = 0;
  int nPass   = 0;

  int mPc;
  bit mZ;

  typedef struct {
    bit          timeout;
    logic [7:0]  fetchAddr;
    int          pulses;
    int          stallBad;
    logic [15:0] instExec;
    logic        zAfter;
    logic [7:0]  pcAfter;
    logic [7:0]  addrAfter;
    logic        haltedAfter;
    logic        reqAfter;
  } obs_t;

  logic [15:0] progMem [256];

  arm_sequencer #(.PC_W(PC_W), .RESET_PC(8'h00)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .alu_result (alu_result),
    .inst       (inst),
    .exec1      (exec1),
    .pc         (pc),
    .zflag      (zflag),
    .halted     (halted)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Instruction-level reference: one call retires one instruction.
  function automatic void modelStep(input logic [15:0] w, input logic [15:0] alu, output bit halt);
    int op;
    int target;
    halt   = 1'b0;
    op     = int'(w) / 4096 % 8;
    target = int'(w) % 256;
    if (int'(w) >= 32768) begin
      mZ  = (alu == 16'h0000);
      mPc = (mPc + 1) % 256;
    end else if (op == 1) begin
      mPc = target;
    end else if (op == 2) begin
      mPc = mZ ? target : (mPc + 1) % 256;
    end else if (op == 3) begin
      halt = 1'b1;
    end else begin
      mPc = (mPc + 1) % 256;
    end
  endfunction

  // Serve one instruction: wait for the fetch, stall lat cycles, deliver the
  // word, sprinkle stray valids during execute, and record what was seen.
  task automatic applyStimulus(input logic [15:0] word, input int lat, input logic [15:0] alu, output obs_t o);
    logic [15:0] instBefore;
    int waitN;
    o = '{default: '0};
    waitN = 0;
    while (imem_req !== 1'b1 && waitN < 50) begin
      @(negedge clk);
      waitN++;
    end
    if (imem_req !== 1'b1) begin
      o.timeout = 1'b1;
      return;
    end
    o.fetchAddr = imem_addr;
    instBefore  = inst;
    alu_result  = alu;
    for (int k = 0; k < lat; k++) begin
      imem_valid = 1'b0;
      imem_rdata = 16'($urandom);
      @(negedge clk);
      if (exec1 !== 1'b0 || inst !== instBefore || imem_req !== 1'b1) o.stallBad++;
    end
    imem_valid = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    if (exec1 === 1'b1) o.pulses++;
    o.instExec = inst;
    imem_valid = 1'($urandom_range(0, 1));
    imem_rdata = 16'($urandom);
    @(negedge clk);
    if (exec1 === 1'b1) o.pulses++;
    o.zAfter   = zflag;
    imem_valid = 1'($urandom_range(0, 1));
    imem_rdata = 16'($urandom);
    @(negedge clk);
    imem_valid = 1'b0;
    if (exec1 === 1'b1) o.pulses++;
    o.pcAfter     = pc;
    o.addrAfter   = imem_addr;
    o.haltedAfter = halted;
    o.reqAfter    = imem_req;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; imem_valid = 1'b0; imem_rdata = 16'h0; alu_result = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nChecks++; if (pc !== 8'h00) $display("[TB] FAIL reset_pc: got %h want 00", pc); else nPass++;
    nChecks++; if ({inst, zflag, exec1, imem_req, halted} !== 20'h0)
      $display("[TB] FAIL reset_outputs: inst=%h z=%b exec1=%b req=%b halted=%b want all zero", inst, zflag, exec1, imem_req, halted);
    else nPass++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    nChecks++; if (imem_req !== 1'b0) $display("[TB] FAIL idle_no_run_req: got %b want 0", imem_req); else nPass++;
    mPc = 0; mZ = 1'b0;
  endtask

  task automatic test_first_fetch();
    obs_t o; bit h;
    run = 1'b1;
    @(negedge clk);
    nChecks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00)
      $display("[TB] FAIL first_req: req=%b addr=%h want 1/00", imem_req, imem_addr); else nPass++;
    applyStimulus(16'h8000, 1, 16'h0003, o); modelStep(16'h8000, 16'h0003, h);
    nChecks++; if (o.timeout || o.fetchAddr !== 8'h00) $display("[TB] FAIL first_addr: got %h want 00", o.fetchAddr); else nPass++;
    nChecks++; if (o.pulses != 1) $display("[TB] FAIL first_exec1_pulses: got %0d want 1", o.pulses); else nPass++;
    nChecks++; if (o.instExec !== 16'h8000) $display("[TB] FAIL first_inst: got %h want 8000", o.instExec); else nPass++;
    nChecks++; if (o.pcAfter !== 8'h01 || o.addrAfter !== 8'h01 || o.reqAfter !== 1'b1)
      $display("[TB] FAIL first_next_fetch: pc=%h addr=%h req=%b want 01/01/1", o.pcAfter, o.addrAfter, o.reqAfter); else nPass++;
  endtask

  task automatic test_alu_jz();
    obs_t o; bit h;
    applyStimulus(16'h8123, 2, 16'h0000, o); modelStep(16'h8123, 16'h0000, h);
    nChecks++; if (o.zAfter !== 1'b1) $display("[TB] FAIL zflag_set: got %b want 1", o.zAfter); else nPass++;
    applyStimulus(16'h2040, 1, 16'h1234, o); modelStep(16'h2040, 16'h1234, h);
    nChecks++; if (o.pcAfter !== 8'h40) $display("[TB] FAIL jz_taken_pc: got %h want 40", o.pcAfter); else nPass++;
    applyStimulus(16'h8001, 1, 16'h0005, o); modelStep(16'h8001, 16'h0005, h);
    nChecks++; if (o.zAfter !== 1'b0) $display("[TB] FAIL zflag_clear: got %b want 0", o.zAfter); else nPass++;
    applyStimulus(16'h2040, 1, 16'h0000, o); modelStep(16'h2040, 16'h0000, h);
    nChecks++; if (o.pcAfter !== 8'h42 || o.zAfter !== 1'b0)
      $display("[TB] FAIL jz_not_taken: pc=%h z=%b want 42/0", o.pcAfter, o.zAfter); else nPass++;
  endtask

  task automatic test_jmp_wrap();
    obs_t o; bit h;
    applyStimulus(16'h10FF, 1, 16'h0000, o); modelStep(16'h10FF, 16'h0000, h);
    nChecks++; if (o.pcAfter !== 8'hFF) $display("[TB] FAIL jmp_pc: got %h want ff", o.pcAfter); else nPass++;
    applyStimulus(16'h0000, 1, 16'h0000, o); modelStep(16'h0000, 16'h0000, h);
    nChecks++; if (o.fetchAddr !== 8'hFF) $display("[TB] FAIL nop_fetch_addr: got %h want ff", o.fetchAddr); else nPass++;
    nChecks++; if (o.pcAfter !== 8'h00) $display("[TB] FAIL pc_wrap: got %h want 00", o.pcAfter); else nPass++;
  endtask

  task automatic test_undefined_op();
    obs_t o; bit h;
    applyStimulus(16'h8777, 1, 16'h0000, o); modelStep(16'h8777, 16'h0000, h);
    applyStimulus(16'h5000, 1, 16'hFFFF, o); modelStep(16'h5000, 16'hFFFF, h);
    nChecks++; if (o.pcAfter !== 8'h02 || o.zAfter !== 1'b1)
      $display("[TB] FAIL undef_5000: pc=%h z=%b want 02/1", o.pcAfter, o.zAfter); else nPass++;
    nChecks++; if (o.pulses != 1) $display("[TB] FAIL undef_pulses: got %0d want 1", o.pulses); else nPass++;
    applyStimulus(16'h7ABC, 1, 16'h0001, o); modelStep(16'h7ABC, 16'h0001, h);
    nChecks++; if (o.pcAfter !== 8'h03 || o.zAfter !== 1'b1)
      $display("[TB] FAIL undef_7abc: pc=%h z=%b want 03/1", o.pcAfter, o.zAfter); else nPass++;
  endtask

  task automatic test_fetch_stall();
    obs_t o; bit h;
    applyStimulus(16'h8ABC, 5, 16'h0001, o); modelStep(16'h8ABC, 16'h0001, h);
    nChecks++; if (o.stallBad != 0) $display("[TB] FAIL stall_hold: bad cycles %0d want 0", o.stallBad); else nPass++;
    nChecks++; if (o.pulses != 1 || o.instExec !== 16'h8ABC)
      $display("[TB] FAIL stall_exec: pulses=%0d inst=%h want 1/8abc", o.pulses, o.instExec); else nPass++;
    nChecks++; if (o.pcAfter !== 8'h04 || o.zAfter !== 1'b0)
      $display("[TB] FAIL stall_result: pc=%h z=%b want 04/0", o.pcAfter, o.zAfter); else nPass++;
  endtask

  task automatic test_random();
    obs_t o; bit h;
    logic [15:0] w;
    logic [15:0] alu;
    int expAddr;
    for (int a = 0; a < 256; a++) begin
      w = 16'($urandom);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: w[15] = 1'b1;
        5:             w[15:12] = 4'b0000;
        6:             w[15:12] = 4'b0001;
        7:             w[15:12] = 4'b0010;
        default: begin w[15] = 1'b0; w[14] = 1'b1; end
      endcase
      progMem[a] = w;
    end
    for (int i = 0; i < 40; i++) begin
      expAddr = mPc;
      w   = progMem[mPc];
      alu = ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom);
      applyStimulus(w, $urandom_range(1, 4), alu, o);
      modelStep(w, alu, h);
      nChecks++;
      if (o.timeout) begin
        $display("[TB] FAIL rand_timeout: no fetch request at step %0d", i);
        break;
      end else nPass++;
      nChecks++; if (o.fetchAddr !== 8'(expAddr)) $display("[TB] FAIL rand_addr[%0d]: got %h want %h", i, o.fetchAddr, 8'(expAddr)); else nPass++;
      nChecks++; if (o.pulses != 1) $display("[TB] FAIL rand_pulses[%0d]: got %0d want 1", i, o.pulses); else nPass++;
      nChecks++; if (o.instExec !== w) $display("[TB] FAIL rand_inst[%0d]: got %h want %h", i, o.instExec, w); else nPass++;
      nChecks++; if (o.zAfter !== mZ) $display("[TB] FAIL rand_zflag[%0d]: got %b want %b", i, o.zAfter, mZ); else nPass++;
      nChecks++; if (o.pcAfter !== 8'(mPc)) $display("[TB] FAIL rand_pc[%0d]: got %h want %h", i, o.pcAfter, 8'(mPc)); else nPass++;
      nChecks++; if (o.stallBad != 0) $display("[TB] FAIL rand_stall[%0d]: bad cycles %0d want 0", i, o.stallBad); else nPass++;
    end
  endtask

  task automatic test_halt();
    obs_t o; bit h;
    logic [7:0] pcBefore;
    int bad;
    pcBefore = 8'(mPc);
    applyStimulus(16'h3000, 1, 16'h0000, o); modelStep(16'h3000, 16'h0000, h);
    nChecks++; if (o.haltedAfter !== 1'b1 || o.reqAfter !== 1'b0 || !h)
      $display("[TB] FAIL halt_enter: halted=%b req=%b want 1/0", o.haltedAfter, o.reqAfter); else nPass++;
    nChecks++; if (o.pcAfter !== pcBefore) $display("[TB] FAIL halt_pc: got %h want %h", o.pcAfter, pcBefore); else nPass++;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      run        = 1'($urandom_range(0, 1));
      imem_valid = 1'($urandom_range(0, 1));
      imem_rdata = 16'($urandom);
      @(negedge clk);
      if (halted !== 1'b1 || imem_req !== 1'b0 || exec1 !== 1'b0 || pc !== pcBefore) bad++;
    end
    nChecks++; if (bad != 0) $display("[TB] FAIL halt_sticky: bad cycles %0d want 0", bad); else nPass++;
    rst_n = 1'b0; run = 1'b0; imem_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mPc = 0; mZ = 1'b0;
    nChecks++; if (halted !== 1'b0 || pc !== 8'h00 || imem_req !== 1'b0 || inst !== 16'h0 || zflag !== 1'b0)
      $display("[TB] FAIL halt_reset: halted=%b pc=%h req=%b inst=%h z=%b want 0/00/0/0000/0", halted, pc, imem_req, inst, zflag);
    else nPass++;
  endtask

  task automatic test_reset_mid_fetch();
    obs_t o; bit h;
    int bad;
    run = 1'b1;
    applyStimulus(16'h1077, 1, 16'h0000, o); modelStep(16'h1077, 16'h0000, h);
    nChecks++; if (o.pcAfter !== 8'h77 || o.reqAfter !== 1'b1)
      $display("[TB] FAIL midfetch_setup: pc=%h req=%b want 77/1", o.pcAfter, o.reqAfter); else nPass++;
    imem_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0; run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mPc = 0; mZ = 1'b0;
    nChecks++; if (imem_req !== 1'b0 || pc !== 8'h00 || inst !== 16'h0)
      $display("[TB] FAIL midfetch_reset: req=%b pc=%h inst=%h want 0/00/0000", imem_req, pc, inst); else nPass++;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      imem_valid = 1'b1;
      imem_rdata = 16'h8BAD;
      @(negedge clk);
      if (imem_req !== 1'b0 || exec1 !== 1'b0 || inst !== 16'h0) bad++;
    end
    imem_valid = 1'b0;
    nChecks++; if (bad != 0) $display("[TB] FAIL late_valid_ignored: bad cycles %0d want 0", bad); else nPass++;
    run = 1'b1;
    applyStimulus(16'h8000, 1, 16'h0007, o); modelStep(16'h8000, 16'h0007, h);
    nChecks++; if (o.timeout || o.fetchAddr !== 8'h00 || o.pcAfter !== 8'h01)
      $display("[TB] FAIL restart: addr=%h pc=%h want 00/01", o.fetchAddr, o.pcAfter); else nPass++;
  endtask

  // Absolute time bound in case the design stops responding entirely.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Test sequence.
  initial begin
    test_reset();
    test_first_fetch();
    test_alu_jz();
    test_jmp_wrap();
    test_undefined_op();
    test_fetch_stall();
    test_random();
    test_halt();
    test_reset_mid_fetch();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
